ocx_tlx_framer_cmd_dequeue: RTL

//  Downstream consumer of the framer command FIFO. Pops 172-bit command entries when TL credits allow.

---
 rtl/ocx_tlx_framer_cmd_dequeue.sv | 84 ++++++++
 1 files changed

// File: rtl/ocx_tlx_framer_cmd_dequeue.sv
// Pops framer command FIFO entries when command/data credits allow and holds each one
// for the flit packer under a valid/ack handshake; tracks host credit returns.
module ocx_tlx_framer_cmd_dequeue #(
    parameter int CMD_CREDIT_MAX  = 16,
    parameter int DATA_CREDIT_MAX = 32,
    parameter int CRED_WIDTH      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fifo_data_available,
    input  logic [171:0]          fifo_data_out,
    output logic                  fifo_rd_done,
    output logic                  cmd_valid,
    output logic [171:0]          cmd_data,
    input  logic                  cmd_ack,
    input  logic                  cmd_credit_return,
    input  logic [2:0]            data_credit_return,
    output logic [CRED_WIDTH-1:0] cmd_credit_count,
    output logic [CRED_WIDTH-1:0] data_credit_count,
    output logic                  credit_overflow_error
);

    // state   | meaning
    // IDLE    | nothing presented to the packer
    // HOLD    | cmd_data presented, waiting for cmd_ack
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam int SW = CRED_WIDTH + 1;
    localparam logic [SW-1:0]         CMD_MAX_W  = SW'(CMD_CREDIT_MAX);
    localparam logic [SW-1:0]         DATA_MAX_W = SW'(DATA_CREDIT_MAX);
    localparam logic [CRED_WIDTH-1:0] CMD_MAX_C  = CRED_WIDTH'(CMD_CREDIT_MAX);
    localparam logic [CRED_WIDTH-1:0] DATA_MAX_C = CRED_WIDTH'(DATA_CREDIT_MAX);

    logic [0:0]    state_q;
    logic [2:0]    need;
    logic          eligible;
    logic          load;
    logic [SW-1:0] cmd_sum;
    logic [SW-1:0] data_sum;
    logic          cmd_over;
    logic          data_over;

    always_comb begin
        // Encodings 5..7 are malformed; treat them as the largest legal request.
        need     = (fifo_data_out[171:169] > 3'd4) ? 3'd4 : fifo_data_out[171:169];
        eligible = fifo_data_available
                   && (cmd_credit_count != '0)
                   && (data_credit_count >= CRED_WIDTH'(need));
        load     = !reset && eligible && ((state_q == ST_IDLE) || cmd_ack);

        cmd_sum  = {1'b0, cmd_credit_count} - SW'(load) + SW'(cmd_credit_return);
        data_sum = {1'b0, data_credit_count} - (load ? SW'(need) : '0)
                   + SW'(data_credit_return);

        cmd_over  = (cmd_sum > CMD_MAX_W);
        data_over = (data_sum > DATA_MAX_W);
    end

    assign fifo_rd_done = load;
    assign cmd_valid    = (state_q == ST_HOLD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q               <= ST_IDLE;
            cmd_data              <= '0;
            cmd_credit_count      <= CMD_MAX_C;
            data_credit_count     <= DATA_MAX_C;
            credit_overflow_error <= 1'b0;
        end else begin
            if (load) begin
                cmd_data <= fifo_data_out;
                state_q  <= ST_HOLD;
            end else if (cmd_ack) begin
                state_q  <= ST_IDLE;
            end

            cmd_credit_count      <= cmd_over  ? CMD_MAX_C  : cmd_sum[CRED_WIDTH-1:0];
            data_credit_count     <= data_over ? DATA_MAX_C : data_sum[CRED_WIDTH-1:0];
            credit_overflow_error <= credit_overflow_error | cmd_over | data_over;
        end
    end

endmodule
